// File: rtl/subtract_sequencer_pkg.sv
// Shared types and constants for the two-operand subtract sequencer:
// FSM state encoding, one-hot LED patterns and default timing parameters.
package subtract_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_GET_A = 2'd0,
        ST_GET_B = 2'd1,
        ST_RUN   = 2'd2,
        ST_SHOW  = 2'd3
    } state_t;

    localparam logic [3:0] LED_GET_A = 4'b0001;
    localparam logic [3:0] LED_GET_B = 4'b0010;
    localparam logic [3:0] LED_RUN   = 4'b0100;
    localparam logic [3:0] LED_SHOW  = 4'b1000;

    // 10 ms at 100 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
    localparam int DEFAULT_TIMEOUT_CYCLES  = 1024;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer, counting debouncer and rising-edge detector for a
// raw pushbutton; press is a registered one-cycle pulse on each accepted 0->1.
module button_debounce
    import subtract_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] COUNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] count;

    // The count only advances while the synchronized input disagrees with the
    // accepted level; any agreeing cycle restarts it, so it never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= 2'b00;
            level <= 1'b0;
            count <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], button};
            press <= 1'b0;
            if (sync[1] == level) begin
                count <= '0;
            end else if (count >= COUNT_LAST) begin
                level <= sync[1];
                count <= '0;
                press <= sync[1];
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/subtract_sequencer.sv
// Collects two operands from the switches on debounced button presses,
// launches an external subtractor, and holds its result or a timeout flag.
module subtract_sequencer
    import subtract_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        CLK100MHZ,
    input  logic        Reset,
    input  logic [15:0] SW,
    input  logic        Center,
    input  logic        sub_done,
    input  logic [15:0] sub_diff,
    input  logic        sub_borrow,
    output logic        sub_start,
    output logic [15:0] A,
    output logic [15:0] B,
    output logic [15:0] Result,
    output logic        Negative,
    output logic        Valid,
    output logic        Error,
    output logic [3:0]  LED
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES);

    state_t        state;
    logic          press;
    logic [TW-1:0] timeout_count;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_button (
        .clk    (CLK100MHZ),
        .rst    (Reset),
        .button (Center),
        .press  (press)
    );

    // sub_start is high only in the first RUN cycle, so it also marks the
    // cycle in which a sub_done must be ignored.
    always_ff @(posedge CLK100MHZ or posedge Reset) begin
        if (Reset) begin
            state         <= ST_GET_A;
            A             <= '0;
            B             <= '0;
            Result        <= '0;
            Negative      <= 1'b0;
            Valid         <= 1'b0;
            Error         <= 1'b0;
            sub_start     <= 1'b0;
            LED           <= LED_GET_A;
            timeout_count <= '0;
        end else begin
            case (state)
                ST_GET_A: begin
                    if (press) begin
                        A     <= SW;
                        state <= ST_GET_B;
                        LED   <= LED_GET_B;
                    end
                end
                ST_GET_B: begin
                    if (press) begin
                        B             <= SW;
                        state         <= ST_RUN;
                        LED           <= LED_RUN;
                        sub_start     <= 1'b1;
                        timeout_count <= TW'(1);
                    end
                end
                ST_RUN: begin
                    sub_start <= 1'b0;
                    if (!sub_start && sub_done) begin
                        Result        <= sub_diff;
                        Negative      <= sub_borrow;
                        Valid         <= 1'b1;
                        Error         <= 1'b0;
                        state         <= ST_SHOW;
                        LED           <= LED_SHOW;
                        timeout_count <= '0;
                    end else if (timeout_count >= TIMEOUT_LAST) begin
                        Valid         <= 1'b0;
                        Error         <= 1'b1;
                        state         <= ST_SHOW;
                        LED           <= LED_SHOW;
                        timeout_count <= '0;
                    end else begin
                        timeout_count <= timeout_count + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (press) begin
                        Valid <= 1'b0;
                        Error <= 1'b0;
                        state <= ST_GET_A;
                        LED   <= LED_GET_A;
                    end
                end
                default: begin
                    state <= ST_GET_A;
                    LED   <= LED_GET_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_subtract_sequencer.sv
// Directed-plus-random bench for subtract_sequencer with a 3-cycle subtractor
// model, short debounce (4) and timeout (16) settings.
module tb_subtract_sequencer;

    localparam logic [3:0] L_GET_A = 4'b0001;
    localparam logic [3:0] L_GET_B = 4'b0010;
    localparam logic [3:0] L_RUN   = 4'b0100;
    localparam logic [3:0] L_SHOW  = 4'b1000;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sw;
    logic        center;
    logic        model_done = 1'b0;
    logic        stray = 1'b0;
    logic        sub_done;
    logic [15:0] sub_diff = '0;
    logic        sub_borrow = 1'b0;
    logic        sub_start;
    logic [15:0] a_out, b_out, result;
    logic        negative, valid, error;
    logic [3:0]  led;

    int total = 0;
    int bad = 0;
    int start_pulses = 0;
    int reply_cnt = 0;
    bit reply_en = 1'b1;
    logic [16:0] exp_q[$];

    assign sub_done = model_done | stray;

    subtract_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .CLK100MHZ  (clk),
        .Reset      (rst),
        .SW         (sw),
        .Center     (center),
        .sub_done   (sub_done),
        .sub_diff   (sub_diff),
        .sub_borrow (sub_borrow),
        .sub_start  (sub_start),
        .A          (a_out),
        .B          (b_out),
        .Result     (result),
        .Negative   (negative),
        .Valid      (valid),
        .Error      (error),
        .LED        (led)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (sub_start) start_pulses++;

    // Subtractor: answers A-B three cycles after the sub_start cycle.
    always @(posedge clk) begin
        model_done <= 1'b0;
        if (sub_start && reply_en) begin
            reply_cnt <= 2;
        end else if (reply_cnt > 0) begin
            reply_cnt <= reply_cnt - 1;
            if (reply_cnt == 1) begin
                model_done <= 1'b1;
                sub_diff   <= a_out - b_out;
                sub_borrow <= (a_out < b_out);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press_until(input logic [3:0] exp_led, input string tag);
        center = 1'b1;
        for (int i = 0; i < 20 && led !== exp_led; i++) tick();
        check(tag, 32'(led), 32'(exp_led));
    endtask

    task automatic release_btn();
        center = 1'b0;
        repeat (10) tick();
    endtask

    task automatic wait_led(input logic [3:0] exp_led, input string tag);
        for (int i = 0; i < 30 && led !== exp_led; i++) tick();
        check(tag, 32'(led), 32'(exp_led));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_led"}, 32'(led), 32'(L_GET_A));
        check({tag, "_a"}, 32'(a_out), 32'h0);
        check({tag, "_b"}, 32'(b_out), 32'h0);
        check({tag, "_result"}, 32'(result), 32'h0);
        check({tag, "_flags"}, 32'({negative, valid, error, sub_start}), 32'h0);
    endtask

    initial begin
        logic [15:0] a_v, b_v, d_v;
        logic [16:0] exp_v;
        logic [15:0] last_result;
        logic        last_neg;
        int          s0;

        rst = 1'b1;
        center = 1'b0;
        sw = '0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // sub_done outside RUN must be ignored
        stray = 1'b1;
        tick();
        stray = 1'b0;
        tick();
        check("stray_valid", 32'(valid), 32'h0);
        check("stray_led", 32'(led), 32'(L_GET_A));

        // directed operand pair
        sw = 16'h0002;
        press_until(L_GET_B, "dir_press_a");
        check("dir_a", 32'(a_out), 32'h0002);
        release_btn();
        sw = 16'h00F0;
        s0 = start_pulses;
        press_until(L_RUN, "dir_press_b");
        center = 1'b0;
        check("dir_b", 32'(b_out), 32'h00F0);
        check("dir_sub_start", 32'(sub_start), 32'h1);
        exp_q.push_back({1'b1, 16'hFF12});
        wait_led(L_SHOW, "dir_show");
        exp_v = exp_q.pop_front();
        check("dir_result", 32'(result), 32'(exp_v[15:0]));
        check("dir_negative", 32'(negative), 32'(exp_v[16]));
        check("dir_valid", 32'(valid), 32'h1);
        check("dir_one_start", 32'(start_pulses - s0), 32'h1);
        repeat (10) tick();
        check("dir_hold_show", 32'(led), 32'(L_SHOW));
        press_until(L_GET_A, "dir_press_show");
        check("dir_valid_clr", 32'({valid, error}), 32'h0);
        check("dir_result_kept", 32'(result), 32'hFF12);
        check("dir_ab_kept", {a_out, b_out}, 32'h000200F0);
        release_btn();

        // short glitches must not be accepted
        sw = 16'hBEEF;
        repeat (3) begin
            center = 1'b1;
            tick();
            tick();
            center = 1'b0;
            repeat (4) tick();
        end
        repeat (6) tick();
        check("glitch_led", 32'(led), 32'(L_GET_A));
        check("glitch_a", 32'(a_out), 32'h0002);

        // random operand pairs, including equal and extreme operands
        for (int r = 0; r < 6; r++) begin
            a_v = 16'($urandom_range(0, 65535));
            b_v = 16'($urandom_range(0, 65535));
            if (r == 0) b_v = a_v;
            if (r == 1) begin a_v = 16'h0000; b_v = 16'hFFFF; end
            if (r == 2) begin a_v = 16'hFFFF; b_v = 16'h0000; end
            sw = a_v;
            press_until(L_GET_B, "rnd_press_a");
            check("rnd_a", 32'(a_out), 32'(a_v));
            release_btn();
            sw = b_v;
            press_until(L_RUN, "rnd_press_b");
            center = 1'b0;
            check("rnd_sub_start", 32'(sub_start), 32'h1);
            d_v = a_v - b_v;
            exp_q.push_back({(a_v < b_v), d_v});
            if (r == 3) begin
                // a completion strobe coinciding with sub_start is not a result
                stray = 1'b1;
                tick();
                stray = 1'b0;
                check("rnd_early_done", 32'(led), 32'(L_RUN));
            end
            sw = 16'h5A5A;
            wait_led(L_SHOW, "rnd_show");
            exp_v = exp_q.pop_front();
            check("rnd_result", 32'(result), 32'(exp_v[15:0]));
            check("rnd_negative", 32'(negative), 32'(exp_v[16]));
            check("rnd_valid_err", 32'({valid, error}), 32'h2);
            check("rnd_ab_stable", {a_out, b_out}, {a_v, b_v});
            last_result = exp_v[15:0];
            last_neg = exp_v[16];
            repeat (8) tick();
            press_until(L_GET_A, "rnd_press_show");
            release_btn();
        end

        // timeout with a press arriving mid-RUN
        sw = 16'h1234;
        press_until(L_GET_B, "to_press_a");
        release_btn();
        sw = 16'h4321;
        reply_en = 1'b0;
        press_until(L_RUN, "to_press_b");
        center = 1'b0;
        check("to_sub_start", 32'(sub_start), 32'h1);
        for (int t = 1; t < 16; t++) begin
            tick();
            if (t == 7) center = 1'b1;
            check("to_still_run", 32'(led), 32'(L_RUN));
        end
        tick();
        check("to_show", 32'(led), 32'(L_SHOW));
        check("to_err_valid", 32'({error, valid}), 32'h2);
        check("to_result_kept", 32'(result), 32'(last_result));
        check("to_neg_kept", 32'(negative), 32'(last_neg));
        repeat (3) tick();
        center = 1'b0;
        repeat (10) tick();
        check("to_press_dropped", 32'(led), 32'(L_SHOW));
        reply_en = 1'b1;
        press_until(L_GET_A, "to_press_show");
        check("to_flags_clr", 32'({error, valid}), 32'h0);
        release_btn();

        // reset one cycle after sub_start
        sw = 16'h00AA;
        press_until(L_GET_B, "rst_press_a");
        release_btn();
        sw = 16'h0055;
        press_until(L_RUN, "rst_press_b");
        center = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check_reset_outputs("midrun_reset");
        tick();
        rst = 1'b0;
        repeat (5) tick();
        check("late_done_led", 32'(led), 32'(L_GET_A));
        check("late_done_valid", 32'({valid, result}), 32'h0);

        // button held through reset release needs a full debounce
        sw = 16'hC3C3;
        center = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("held_no_early_press", 32'(led), 32'(L_GET_A));
        end
        press_until(L_GET_B, "held_press");
        check("held_a", 32'(a_out), 32'hC3C3);
        release_btn();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
